serial_sub: RTL

//  Bit-serial WIDTH-bit subtractor: diff = a_in - b_in - bin, one bit per clock, LSB first.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_sub_full_sub.sv | 19 +
 rtl/serial_sub.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// full-subtractor truth tables, indexed by {a, b, bin}.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit i of each table is the cell output for the input combination {a, b, bin} == i.
  localparam logic [7:0] FS_DIFF_TT = 8'b1001_0110;
  localparam logic [7:0] FS_BOUT_TT = 8'b1000_1110;

endpackage

// File: rtl/serial_sub_full_sub.sv
// Combinational full-subtractor cell (a - b - bin -> d, bout); the subtraction
// counterpart of the full-adder cell, looked up from the shared truth tables.
module serial_sub_full_sub
  import serial_sub_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic [2:0] idx;

  assign idx    = {a_i, b_i, bin_i};
  assign d_o    = FS_DIFF_TT[idx];
  assign bout_o = FS_BOUT_TT[idx];

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a_in - b_in - bin), LSB first, with a
// start/busy/valid handshake. Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, d_sh_q, d_sh_d;
  logic             brw_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, valid_q, bout_q;
  logic [WIDTH-1:0] diff_q;
  logic             d_bit, bo_bit;

  serial_sub_full_sub u_cell (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0]),
    .bin_i (brw_q),
    .d_o   (d_bit),
    .bout_o(bo_bit)
  );

  assign d_sh_d = {d_bit, d_sh_q[WIDTH-1:1]};
  assign cnt_d  = cnt_q + CW'(1);

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  // On the last RUN cycle the operand LSBs are the MSBs, so overflow is resolved as diff is.
  logic ovf_d;
  assign ovf_d = (a_sh_q[0] != b_sh_q[0]) && (d_bit != a_sh_q[0]);
  assign ovf   = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            brw_q   <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          d_sh_q <= d_sh_d;
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          brw_q  <= bo_bit;
          cnt_q  <= cnt_d;
          // Results are loaded with the final bit so they are already visible in DONE.
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            diff_q  <= d_sh_d;
            bout_q  <= bo_bit;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule
